stopwatch_time_counter: RTL and testbench

//  Consumes the 1-cycle-per-second tick from the clock divider and keeps stopwatch time as MM:SS BCD digits.

---
 rtl/stopwatch_time_counter.sv | 134 +++++++++++++
 tb/tb_stopwatch_time_counter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch MM:SS BCD time counter with an IDLE/RUNNING/PAUSED control FSM.
// Counts one-second ticks while running; start/stop and clear act on rising edges of their buttons.
module stopwatch_time_counter #(
  parameter int unsigned MaxMinutes = 59
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       start_stop_i,
  input  logic       clear_i,
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] min_tens_o,
  output logic       running_o,
  output logic       wrap_o
);

  localparam logic [3:0] MaxMinTens = 4'(MaxMinutes / 10);
  localparam logic [3:0] MaxMinOnes = 4'(MaxMinutes % 10);

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StPaused
  } state_e;

  state_e     state_q, state_d;
  logic       ss_prev_q, clr_prev_q;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;

  logic ss_edge, clr_edge, count_en, at_max;

  assign ss_edge  = start_stop_i & ~ss_prev_q;
  assign clr_edge = clear_i & ~clr_prev_q;
  // A tick counts in RUNNING even when start/stop pauses on the same edge.
  assign count_en = (state_q == StRunning) && tick_i && !clr_edge;
  assign at_max   = (min_tens_q == MaxMinTens) && (min_ones_q == MaxMinOnes) &&
                    (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

  // Control FSM next state; clear has top priority.
  always_comb begin
    state_d = state_q;
    if (clr_edge) begin
      state_d = StIdle;
    end else if (ss_edge) begin
      unique case (state_q)
        StIdle:    state_d = StRunning;
        StRunning: state_d = StPaused;
        StPaused:  state_d = StRunning;
        default:   state_d = StIdle;
      endcase
    end
  end

  assign running_d = (state_d == StRunning);

  // BCD carry chain with wrap at MaxMinutes:59.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    if (clr_edge) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (count_en) begin
      if (at_max) begin
        sec_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        min_ones_d = 4'd0;
        min_tens_d = 4'd0;
        wrap_d     = 1'b1;
      end else if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            min_tens_d = min_tens_q + 4'd1;
          end
        end
      end
    end
  end

  // State, button history and registered outputs.
  // Button history resets high so a button held through reset yields no edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_prev_q  <= start_stop_i;
      clr_prev_q <= clear_i;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sec_ones_o = sec_ones_q;
  assign sec_tens_o = sec_tens_q;
  assign min_ones_o = min_ones_q;
  assign min_tens_o = min_tens_q;
  assign running_o  = running_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench for stopwatch_time_counter: a seconds-count reference model pushes the
// expected output word per cycle, the observed word is pushed after the edge, and each
// scenario task drains and compares both queues.
module tb_stopwatch_time_counter;

  localparam int unsigned MaxMin = 59;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, wrap;

  stopwatch_time_counter #(.MaxMinutes(MaxMin)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tick_i      (tick),
    .start_stop_i(start_stop),
    .clear_i     (clear),
    .sec_ones_o  (sec_ones),
    .sec_tens_o  (sec_tens),
    .min_ones_o  (min_ones),
    .min_tens_o  (min_tens),
    .running_o   (running),
    .wrap_o      (wrap)
  );

  always #5 clk = ~clk;

  // Output word: {min_tens, min_ones, sec_tens, sec_ones, running, wrap}
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int vectors = 0;
  int fails = 0;

  // Reference model: time as total seconds, state 0=idle 1=running 2=paused
  int m_t;
  int m_st;
  bit m_ss_prev, m_clr_prev;

  function automatic logic [17:0] pack_exp(int t, bit run, bit wr);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), run, wr};
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_st = 0;
    m_ss_prev = 1'b1;
    m_clr_prev = 1'b1;
  endtask

  // Drive one cycle of inputs, push the model's expectation, capture the DUT after the edge.
  task automatic step(input bit ss, input bit clr, input bit tk);
    bit ss_e, clr_e, wr;
    start_stop = ss;
    clear = clr;
    tick = tk;
    ss_e = ss && !m_ss_prev;
    clr_e = clr && !m_clr_prev;
    wr = 1'b0;
    if (clr_e) begin
      m_t = 0;
      m_st = 0;
    end else begin
      if (m_st == 1 && tk) begin
        if (m_t == int'(MaxMin) * 60 + 59) begin
          m_t = 0;
          wr = 1'b1;
        end else begin
          m_t = m_t + 1;
        end
      end
      if (ss_e) m_st = (m_st == 1) ? 2 : 1;
    end
    m_ss_prev = ss;
    m_clr_prev = clr;
    exp_q.push_back(pack_exp(m_t, m_st == 1, wr));
    @(posedge clk);
    #1;
    obs_q.push_back({min_tens, min_ones, sec_tens, sec_ones, running, wrap});
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    logic [17:0] o;
    rst_n = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    o = {min_tens, min_ones, sec_tens, sec_ones, running, wrap};
    vectors++;
    if (o !== 18'd0) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", o, 18'd0);
    end
  endtask

  task automatic test_start_61();
    logic [17:0] e, o;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_ticks(61);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL start_61: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_bcd_carry();
    logic [17:0] e, o;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_ticks(9);
    run_ticks(1);
    run_ticks(49);
    run_ticks(1);
    run_ticks(550);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL bcd_carry: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [17:0] e, o;
    int wrap_cycles;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_ticks(int'(MaxMin) * 60 + 59);
    wrap_cycles = 0;
    run_ticks(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o[0]) wrap_cycles++;
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL wrap_seq: got %h want %h", o, e);
      end
    end
    vectors++;
    if (wrap_cycles !== 1) begin
      fails++;
      $display("FAIL wrap_pulse_count: got %0d want 1", wrap_cycles);
    end
  endtask

  task automatic test_pause_with_tick();
    logic [17:0] e, o;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_ticks(5);
    step(1'b1, 1'b0, 1'b1);
    run_ticks(10);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL pause_tick: got %h want %h", o, e);
      end
    end
    o = {min_tens, min_ones, sec_tens, sec_ones, running, wrap};
    vectors++;
    if (o !== pack_exp(7, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL pause_resume_0007: got %h want %h", o, pack_exp(7, 1'b1, 1'b0));
    end
  endtask

  task automatic test_clear_with_tick();
    logic [17:0] e, o;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_ticks(150);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, (i % 3) == 0);
    step(1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL clear_tick: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [17:0] e, o;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_ticks(12 * 60 + 34);
    // Assert reset between clock edges and look before the next edge.
    #3;
    start_stop = 1'b1;
    rst_n = 1'b0;
    #1;
    o = {min_tens, min_ones, sec_tens, sec_ones, running, wrap};
    vectors++;
    if (o !== 18'd0) begin
      fails++;
      $display("FAIL async_reset: got %h want %h", o, 18'd0);
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_release: got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_61();
    test_bcd_carry();
    test_wrap();
    test_pause_with_tick();
    test_clear_with_tick();
    test_async_reset();
    vectors++;
    if (exp_q.size() != obs_q.size()) begin
      fails++;
      $display("FAIL queue_balance: got %0d observed want %0d", obs_q.size(), exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
